bmd_256_latency_drain: RTL and testbench
========================================

Name: bmd_256_latency_drain

Overview:
- TX-side consumer of the 8192-deep RX timestamp FIFO: the FIFO holds 48-bit waiting_counter values captured at each CQ start-of-packet.
- Once the FIFO's read trigger is high, the block pops one stored timestamp per transmitted response packet (tx_sop).
- It computes per-packet latency as counter_at_tx minus stamp, modulo 2^48.
- It keeps last/min/max/sum/count statistics for host readout and flags completion after N_SAMPLES.

Parameters:
TS_W, 48, timestamp and latency width
SUM_W, 64, latency accumulator width
CNT_W, 14, sample and drop counter width
N_SAMPLES, 8192, samples to collect before DONE; must be ≤ 2^CNT_W−1 and equal to the FIFO depth

Ports:
clk  in  1  250 MHz user clock
rst  in  1  synchronous active-high reset
latency_reset_signal  in  1  sync clear of statistics and FSM, same effect as rst
fifo_read_trigger  in  1  from timestamp FIFO stage: FIFO filled, drain allowed
tx_sop  in  1  one-cycle pulse, TX launches a response packet
waiting_counter  in  TS_W  free-running counter shared with RX stage
fifo_counter_value_out  in  TS_W  FIFO dout, valid one cycle after rd_en
fifo_counter_read_en  out  1  FIFO pop, registered, one-cycle pulse
lat_valid  out  1  one-cycle pulse, lat_last updated
lat_last  out  TS_W  most recent latency
lat_min  out  TS_W  minimum latency
lat_max  out  TS_W  maximum latency
lat_sum  out  SUM_W  saturating latency sum
sample_cnt  out  CNT_W  samples accumulated
drop_cnt  out  CNT_W  tx_sop pulses ignored, saturating
done  out  1  level, N_SAMPLES collected

Behaviour:
- Reset (rst or latency_reset_signal): state IDLE. Outputs: rd_en 0, lat_valid 0, lat_last 0, lat_min all-ones, lat_max 0, lat_sum 0, sample_cnt 0, drop_cnt 0, done 0. Reset takes effect mid-operation and any in-flight read is discarded.
- FSM states: IDLE, ARMED, POP, CALC, DONE.
- IDLE: when fifo_read_trigger=1, go to ARMED next cycle.
- ARMED, fifo_read_trigger=0: return to IDLE. This covers FIFO empty and trigger dropped; no rd_en is issued.
- ARMED, tx_sop=1: latch tx_stamp=waiting_counter, go to POP.
- POP: fifo_counter_read_en=1 for exactly this cycle. Next state CALC.
- CALC: fifo_counter_value_out is valid.
  - lat = tx_stamp − dout, truncated to TS_W bits, so wrap-around yields the correct modular difference.
  - Register lat into lat_last and pulse lat_valid in the cycle after CALC, together with the stats update.
  - Next state: DONE if sample_cnt+1 == N_SAMPLES, else ARMED.
- Timing: tx_sop at cycle T → rd_en at T+1 → stats and lat_valid visible at T+3. Minimum tx_sop spacing honoured is 3 cycles.
- Stats update, same cycle as lat_valid:
  - lat_min = min(lat_min, lat); lat_max = max(lat_max, lat).
  - lat_sum += lat, saturating at all-ones.
  - sample_cnt += 1.
- Simultaneous events:
  - tx_sop and trigger fall in the same ARMED cycle: trigger loss wins, tx_sop counts as a drop.
  - trigger falling during POP or CALC is ignored; the sample completes.
- tx_sop seen in IDLE, POP, CALC or DONE: ignored, drop_cnt += 1, saturating at all-ones.
- DONE: done=1 and no further pops. Left only by reset.
- The FIFO must never be popped while empty. Relies on trigger low ⇔ empty and rd_en only being issued from ARMED while trigger high.

Decomposition:
- Package bmd_256_lat_pkg:
  - TS_W, SUM_W, CNT_W constants
  - state enum {IDLE, ARMED, POP, CALC, DONE}
  - lat_t typedef of TS_W bits
- Sub-module bmd_256_lat_stats:
  - inputs: sample valid + lat, clear
  - outputs: last/min/max/sum/count with saturation
- The FSM, tx_stamp latch and subtraction stay in the top module.

Test Plan:
- Single sample: trigger=1, waiting_counter=1000 at tx_sop, FIFO dout=400 → rd_en one pulse at T+1; at T+3 lat_valid=1, lat_last=lat_min=lat_max=lat_sum=600, sample_cnt=1.
- Wrap: stamp=0xFFFF_FFFF_FFF0, counter at tx_sop=0x10 → lat_last=0x20.
- Stats over three samples with latencies 50, 10, 90 → lat_min=10, lat_max=90, lat_sum=150, sample_cnt=3.
- Drops: tx_sop while trigger=0 and tx_sop during POP → no rd_en, drop_cnt=2, stats unchanged.
- Completion: N_SAMPLES=4, six spaced tx_sop pulses → exactly 4 rd_en pulses, done=1 after the 4th lat_valid, drop_cnt=2. Then latency_reset_signal → all outputs at reset values, lat_min=all-ones.
- Trigger loss and reset mid-read: trigger falls in ARMED → IDLE, no pop. latency_reset_signal asserted in CALC → no lat_valid, sample_cnt=0.

Source files
------------

// File: rtl/bmd_256_lat_pkg.sv
// Shared widths, FSM state encoding and latency type for the TX-side timestamp drain.
package bmd_256_lat_pkg;

    localparam int unsigned TS_W  = 48;
    localparam int unsigned SUM_W = 64;
    localparam int unsigned CNT_W = 14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POP   = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [TS_W-1:0] lat_t;

endpackage

// File: rtl/bmd_256_lat_stats.sv
// Latency statistics: last/min/max, saturating sum and sample count, updated on each valid sample.
module bmd_256_lat_stats
    import bmd_256_lat_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             sample_valid,
    input  lat_t             lat,
    output logic             lat_valid,
    output lat_t             lat_last,
    output lat_t             lat_min,
    output lat_t             lat_max,
    output logic [SUM_W-1:0] lat_sum,
    output logic [CNT_W-1:0] sample_cnt
);

    // One extra bit catches accumulator overflow for saturation.
    logic [SUM_W:0] sum_ext_c;

    assign sum_ext_c = {1'b0, lat_sum} + (SUM_W+1)'(lat);

    always_ff @(posedge clk) begin
        if (clr) begin
            lat_valid  <= 1'b0;
            lat_last   <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            lat_sum    <= '0;
            sample_cnt <= '0;
        end else begin
            lat_valid <= sample_valid;
            if (sample_valid) begin
                lat_last <= lat;
                if (lat < lat_min) lat_min <= lat;
                if (lat > lat_max) lat_max <= lat;
                lat_sum <= sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
                if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bmd_256_latency_drain.sv
// Pops one RX timestamp per TX packet once the FIFO is full and measures per-packet latency.
module bmd_256_latency_drain
    import bmd_256_lat_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             latency_reset_signal,
    input  logic             fifo_read_trigger,
    input  logic             tx_sop,
    input  logic [TS_W-1:0]  waiting_counter,
    input  logic [TS_W-1:0]  fifo_counter_value_out,
    output logic             fifo_counter_read_en,
    output logic             lat_valid,
    output logic [TS_W-1:0]  lat_last,
    output logic [TS_W-1:0]  lat_min,
    output logic [TS_W-1:0]  lat_max,
    output logic [SUM_W-1:0] lat_sum,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_t state, state_next;
    logic   clr_c;
    logic   rd_en_next_c;
    logic   stamp_load_c;
    logic   drop_c;
    logic   calc_c;
    lat_t   tx_stamp;
    lat_t   lat_c;

    assign clr_c = rst | latency_reset_signal;
    // Modular difference: wrap of the free-running counter falls out of the truncation.
    assign lat_c = tx_stamp - fifo_counter_value_out;

    always_ff @(posedge clk) begin
        if (clr_c) begin
            state                <= IDLE;
            fifo_counter_read_en <= 1'b0;
            done                 <= 1'b0;
            drop_cnt             <= '0;
            tx_stamp             <= '0;
        end else begin
            state                <= state_next;
            fifo_counter_read_en <= rd_en_next_c;
            done                 <= (state_next == DONE);
            if (stamp_load_c) tx_stamp <= waiting_counter;
            if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        rd_en_next_c = 1'b0;
        stamp_load_c = 1'b0;
        drop_c       = 1'b0;
        calc_c       = 1'b0;
        case (state)
            IDLE: begin
                drop_c = tx_sop;
                if (fifo_read_trigger) state_next = ARMED;
            end
            ARMED: begin
                // Trigger low means FIFO empty: never pop, even on a coincident tx_sop.
                if (!fifo_read_trigger) begin
                    drop_c     = tx_sop;
                    state_next = IDLE;
                end else if (tx_sop) begin
                    stamp_load_c = 1'b1;
                    rd_en_next_c = 1'b1;
                    state_next   = POP;
                end
            end
            POP: begin
                drop_c     = tx_sop;
                state_next = CALC;
            end
            CALC: begin
                drop_c     = tx_sop;
                calc_c     = 1'b1;
                state_next = (sample_cnt == LAST_IDX) ? DONE : ARMED;
            end
            DONE: begin
                drop_c = tx_sop;
            end
            default: state_next = IDLE;
        endcase
    end

    bmd_256_lat_stats u_stats (
        .clk          (clk),
        .clr          (clr_c),
        .sample_valid (calc_c),
        .lat          (lat_c),
        .lat_valid    (lat_valid),
        .lat_last     (lat_last),
        .lat_min      (lat_min),
        .lat_max      (lat_max),
        .lat_sum      (lat_sum),
        .sample_cnt   (sample_cnt)
    );

endmodule

// File: tb/tb_bmd_256_latency_drain.sv
// Scoreboard bench for the latency drain: FIFO model feeds pops, expected latencies are queued per sample.
module tb_bmd_256_latency_drain;

    localparam int unsigned TS_W  = 48;
    localparam int unsigned SUM_W = 64;
    localparam int unsigned CNT_W = 14;
    localparam int unsigned NS    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             latency_reset_signal = 1'b0;
    logic             fifo_read_trigger = 1'b0;
    logic             tx_sop = 1'b0;
    logic [TS_W-1:0]  waiting_counter = '0;
    logic [TS_W-1:0]  fifo_counter_value_out = '0;
    logic             rd_en;
    logic             lat_valid;
    logic [TS_W-1:0]  lat_last, lat_min, lat_max;
    logic [SUM_W-1:0] lat_sum;
    logic [CNT_W-1:0] sample_cnt, drop_cnt;
    logic             done;

    logic [TS_W-1:0]  fifo_q[$];
    logic [TS_W-1:0]  exp_q[$];
    logic [TS_W-1:0]  ones_ts = {TS_W{1'b1}};
    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int r0;

    bmd_256_latency_drain #(.N_SAMPLES(NS)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .latency_reset_signal   (latency_reset_signal),
        .fifo_read_trigger      (fifo_read_trigger),
        .tx_sop                 (tx_sop),
        .waiting_counter        (waiting_counter),
        .fifo_counter_value_out (fifo_counter_value_out),
        .fifo_counter_read_en   (rd_en),
        .lat_valid              (lat_valid),
        .lat_last               (lat_last),
        .lat_min                (lat_min),
        .lat_max                (lat_max),
        .lat_sum                (lat_sum),
        .sample_cnt             (sample_cnt),
        .drop_cnt               (drop_cnt),
        .done                   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: dout valid the cycle after a pop.
    always @(posedge clk) begin
        if (rd_en) begin
            if (fifo_q.size() == 0) chk("pop_empty", 64'd1, 64'd0);
            else fifo_counter_value_out <= fifo_q.pop_front();
        end
    end

    // Scoreboard: every lat_valid must match the oldest expected latency.
    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (lat_valid) begin
            if (exp_q.size() == 0) chk("lat_unexpected", 64'd1, 64'd0);
            else chk("lat_last_sb", 64'(lat_last), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_lat_valid", 64'(lat_valid), 64'd0);
        chk("rst_lat_last", 64'(lat_last), 64'd0);
        chk("rst_lat_min", 64'(lat_min), 64'(ones_ts));
        chk("rst_lat_max", 64'(lat_max), 64'd0);
        chk("rst_lat_sum", lat_sum, 64'd0);
        chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
    endtask

    task automatic clear();
        @(posedge clk); #1; latency_reset_signal = 1'b1;
        @(posedge clk); #1; latency_reset_signal = 1'b0;
        tick(2);
    endtask

    task automatic pulse_sop();
        @(posedge clk); #1; tx_sop = 1'b1;
        @(posedge clk); #1; tx_sop = 1'b0;
    endtask

    // tx_sop at T, pop at T+1, result at T+3; optional extra sop in POP or clear in CALC.
    task automatic sample(input logic [TS_W-1:0] tx_cnt, input logic [TS_W-1:0] stamp,
                          input bit sop_in_pop, input bit rst_in_calc, input bit expect_done);
        logic [TS_W-1:0] e;
        e = tx_cnt - stamp;
        fifo_q.push_back(stamp);
        if (!rst_in_calc) exp_q.push_back(e);
        @(posedge clk); #1; waiting_counter = tx_cnt; tx_sop = 1'b1;
        @(posedge clk); #1; tx_sop = sop_in_pop;
        @(negedge clk); chk("rd_en_t1", 64'(rd_en), 64'd1);
        @(posedge clk); #1; tx_sop = 1'b0; latency_reset_signal = rst_in_calc;
        @(negedge clk);
        chk("rd_en_t2", 64'(rd_en), 64'd0);
        chk("lat_valid_t2", 64'(lat_valid), 64'd0);
        @(posedge clk); #1; latency_reset_signal = 1'b0;
        @(negedge clk);
        chk("lat_valid_t3", 64'(lat_valid), rst_in_calc ? 64'd0 : 64'd1);
        chk("done_t3", 64'(done), expect_done ? 64'd1 : 64'd0);
    endtask

    initial begin
        tick(3);
        check_reset();
        rst = 1'b0;
        fifo_read_trigger = 1'b1;
        tick(2);

        // single sample
        sample(48'd1000, 48'd400, 1'b0, 1'b0, 1'b0);
        chk("single_last", 64'(lat_last), 64'd600);
        chk("single_min", 64'(lat_min), 64'd600);
        chk("single_max", 64'(lat_max), 64'd600);
        chk("single_sum", lat_sum, 64'd600);
        chk("single_cnt", 64'(sample_cnt), 64'd1);

        // counter wrap
        clear();
        sample(48'h10, 48'hFFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
        chk("wrap_last", 64'(lat_last), 64'h20);

        // three-sample stats
        clear();
        sample(48'd1050, 48'd1000, 1'b0, 1'b0, 1'b0);
        sample(48'd2010, 48'd2000, 1'b0, 1'b0, 1'b0);
        sample(48'd3090, 48'd3000, 1'b0, 1'b0, 1'b0);
        chk("stats_min", 64'(lat_min), 64'd10);
        chk("stats_max", 64'(lat_max), 64'd90);
        chk("stats_sum", lat_sum, 64'd150);
        chk("stats_cnt", 64'(sample_cnt), 64'd3);

        // drops: sop with trigger low, sop during POP
        clear();
        fifo_read_trigger = 1'b0;
        tick(2);
        r0 = rd_cnt;
        pulse_sop();
        tick(2);
        chk("drop_idle_no_pop", 64'(rd_cnt - r0), 64'd0);
        chk("drop_idle_cnt", 64'(drop_cnt), 64'd1);
        chk("drop_idle_stats", 64'(sample_cnt), 64'd0);
        fifo_read_trigger = 1'b1;
        tick(2);
        sample(48'd500, 48'd100, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("drop_pop_rd", 64'(rd_cnt - r0), 64'd1);
        chk("drop_pop_cnt", 64'(drop_cnt), 64'd2);
        chk("drop_pop_stats", 64'(sample_cnt), 64'd1);

        // completion after NS samples, extra sops dropped
        clear();
        r0 = rd_cnt;
        sample(48'd110, 48'd100, 1'b0, 1'b0, 1'b0);
        sample(48'd220, 48'd200, 1'b0, 1'b0, 1'b0);
        sample(48'd330, 48'd300, 1'b0, 1'b0, 1'b0);
        sample(48'd440, 48'd400, 1'b0, 1'b0, 1'b1);
        pulse_sop();
        tick(2);
        pulse_sop();
        tick(2);
        chk("done_rd_pulses", 64'(rd_cnt - r0), 64'd4);
        chk("done_level", 64'(done), 64'd1);
        chk("done_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("done_cnt", 64'(sample_cnt), 64'd4);
        chk("done_sum", lat_sum, 64'd100);
        clear();
        check_reset();

        // trigger loss coincident with sop in ARMED
        r0 = rd_cnt;
        @(posedge clk); #1; fifo_read_trigger = 1'b0; tx_sop = 1'b1;
        @(posedge clk); #1; tx_sop = 1'b0;
        tick(2);
        chk("trigloss_no_pop", 64'(rd_cnt - r0), 64'd0);
        chk("trigloss_drop", 64'(drop_cnt), 64'd1);

        // clear during CALC discards the in-flight sample
        fifo_read_trigger = 1'b1;
        tick(2);
        sample(48'd900, 48'd800, 1'b0, 1'b1, 1'b0);
        chk("calc_rst_cnt", 64'(sample_cnt), 64'd0);
        chk("calc_rst_last", 64'(lat_last), 64'd0);
        tick(3);
        chk("calc_rst_pops", 64'(rd_cnt - r0), 64'd1);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("fifo_q_empty", 64'(fifo_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
